// File: rtl/ring_link_arbiter_if.sv
// Link-side bundle of the ring link arbiter: the three inbound packet ports,
// downstream ready, and the shared outbound link plus its status outputs.
interface ring_link_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
);
  logic [DATA_WIDTH-1:0] shiftInLeftData;
  logic                  shiftInLeftCS;
  logic [DATA_WIDTH-1:0] shiftInRightData;
  logic                  shiftInRightCS;
  logic [DATA_WIDTH-1:0] shiftInData;
  logic                  shiftInCS;
  logic                  outReady;
  logic [DATA_WIDTH-1:0] shiftOutData;
  logic                  shiftOutCS;
  logic                  leftFull;
  logic                  rightFull;
  logic                  localFull;
  logic [1:0]            grantId;
  logic [CNT_WIDTH-1:0]  dropCount;

  modport master (
    output shiftInLeftData, shiftInLeftCS, shiftInRightData, shiftInRightCS,
           shiftInData, shiftInCS, outReady,
    input  shiftOutData, shiftOutCS, leftFull, rightFull, localFull,
           grantId, dropCount
  );

  modport slave (
    input  shiftInLeftData, shiftInLeftCS, shiftInRightData, shiftInRightCS,
           shiftInData, shiftInCS, outReady,
    output shiftOutData, shiftOutCS, leftFull, rightFull, localFull,
           grantId, dropCount
  );
endinterface

// File: rtl/ring_link_arbiter.sv
// Shares one outgoing ring link between left, right and local sources using
// per-source packet FIFOs and a round-robin IDLE/SEND/GAP scheduler.
module ring_link_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_WIDTH  = 8
) (
  input logic                shiftInCLK,
  input logic                reset,
  ring_link_arbiter_if.slave link
);

  localparam int NSRC  = 3;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam int SW    = CNT_WIDTH + 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [3:0]           GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam logic [CW-1:0]        FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] DROP_MAX = '1;

  logic [DATA_WIDTH-1:0] mem_q    [NSRC][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d    [NSRC][FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q [NSRC];
  logic [PTR_W-1:0]      wr_ptr_d [NSRC];
  logic [PTR_W-1:0]      rd_ptr_q [NSRC];
  logic [PTR_W-1:0]      rd_ptr_d [NSRC];
  logic [CW-1:0]         count_q  [NSRC];
  logic [CW-1:0]         count_d  [NSRC];

  logic [1:0]            state_q, state_d;
  logic [3:0]            gap_q, gap_d;
  logic [1:0]            rr_q, rr_d;
  logic [1:0]            grant_q, grant_d;
  logic                  out_cs_q, out_cs_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_WIDTH-1:0]  drop_q, drop_d;

  logic [DATA_WIDTH-1:0] in_data [NSRC];
  logic [NSRC-1:0]       in_cs;
  logic [NSRC-1:0]       not_empty;
  logic [NSRC-1:0]       pop;
  logic [NSRC-1:0]       accept;
  logic [NSRC-1:0]       reject;
  logic                  sel_valid;
  logic [1:0]            sel;
  logic [2:0]            cand;
  logic                  launch;
  logic [DATA_WIDTH-1:0] head_data;
  logic [1:0]            rej_num;
  logic [SW-1:0]         drop_sum;

  assign in_data[0] = link.shiftInLeftData;
  assign in_data[1] = link.shiftInRightData;
  assign in_data[2] = link.shiftInData;
  assign in_cs      = {link.shiftInCS, link.shiftInRightCS, link.shiftInLeftCS};

  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      not_empty[i] = (count_q[i] != '0);
    end
  end

  // Round-robin scan starting at the pointer, wrapping left -> right -> local.
  always_comb begin
    sel_valid = 1'b0;
    sel       = 2'd0;
    cand      = 3'd0;
    for (int k = 0; k < NSRC; k++) begin
      cand = 3'(rr_q) + 3'(k);
      if (cand >= 3'd3) begin
        cand = cand - 3'd3;
      end
      if (!sel_valid && not_empty[cand[1:0]]) begin
        sel_valid = 1'b1;
        sel       = cand[1:0];
      end
    end
  end

  assign head_data = mem_q[sel][rd_ptr_q[sel]];

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    rr_d       = rr_q;
    grant_d    = grant_q;
    out_cs_d   = 1'b0;
    out_data_d = out_data_q;
    launch     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (link.outReady && sel_valid) begin
          launch     = 1'b1;
          out_cs_d   = 1'b1;
          out_data_d = head_data;
          grant_d    = sel;
          rr_d       = (sel == 2'd2) ? 2'd0 : sel + 2'd1;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (GAP_CYCLES > 0) begin
          state_d = ST_GAP;
          gap_d   = GAP_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A full FIFO still accepts a push when its head leaves on the same edge.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < NSRC; i++) begin
      pop[i]      = launch && (sel == 2'(i));
      accept[i]   = in_cs[i] && ((count_q[i] != FULL_CNT) || pop[i]);
      reject[i]   = in_cs[i] && !accept[i];
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      if (accept[i]) begin
        mem_d[i][wr_ptr_q[i]] = in_data[i];
        wr_ptr_d[i]           = wr_ptr_q[i] + PTR_W'(1);
      end
      if (pop[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
      end
      count_d[i] = count_q[i] + CW'(accept[i]) - CW'(pop[i]);
    end
  end

  always_comb begin
    rej_num  = 2'(reject[0]) + 2'(reject[1]) + 2'(reject[2]);
    drop_sum = SW'(drop_q) + SW'(rej_num);
    if (drop_sum > SW'(DROP_MAX)) begin
      drop_d = DROP_MAX;
    end else begin
      drop_d = drop_sum[CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge shiftInCLK or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      gap_q      <= 4'd0;
      rr_q       <= 2'd0;
      grant_q    <= 2'd3;
      out_cs_q   <= 1'b0;
      out_data_q <= '0;
      drop_q     <= '0;
      for (int i = 0; i < NSRC; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      rr_q       <= rr_d;
      grant_q    <= grant_d;
      out_cs_q   <= out_cs_d;
      out_data_q <= out_data_d;
      drop_q     <= drop_d;
      for (int i = 0; i < NSRC; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        count_q[i]  <= count_d[i];
      end
    end
  end

  // Payload storage needs no reset; emptiness is tracked by the counts.
  always_ff @(posedge shiftInCLK) begin
    mem_q <= mem_d;
  end

  assign link.shiftOutData = out_data_q;
  assign link.shiftOutCS   = out_cs_q;
  assign link.leftFull     = (count_q[0] == FULL_CNT);
  assign link.rightFull    = (count_q[1] == FULL_CNT);
  assign link.localFull    = (count_q[2] == FULL_CNT);
  assign link.grantId      = grant_q;
  assign link.dropCount    = drop_q;

endmodule

// File: tb/tb_ring_link_arbiter.sv
// Directed vector bench for ring_link_arbiter (depth 2, gap 1, 2-bit drop counter)
// plus a hand-written mid-packet reset sequence.
module tb_ring_link_arbiter;

  typedef struct {
    logic        lcs;
    logic [31:0] ld;
    logic        rcs;
    logic [31:0] rd;
    logic        ccs;
    logic [31:0] cd;
    logic        rdy;
    logic        ecs;
    logic [31:0] edata;
    logic [1:0]  egrant;
    logic [1:0]  edrop;
    logic        elf;
    logic        erf;
    logic        ecf;
  } vec_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  vec_t vecs[$];

  ring_link_arbiter_if #(.DATA_WIDTH(32), .CNT_WIDTH(2)) link_if ();

  ring_link_arbiter #(
    .DATA_WIDTH(32),
    .FIFO_DEPTH(2),
    .GAP_CYCLES(1),
    .CNT_WIDTH (2)
  ) dut (
    .shiftInCLK(clk),
    .reset     (reset),
    .link      (link_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    link_if.shiftInLeftCS    = v.lcs;
    link_if.shiftInLeftData  = v.ld;
    link_if.shiftInRightCS   = v.rcs;
    link_if.shiftInRightData = v.rd;
    link_if.shiftInCS        = v.ccs;
    link_if.shiftInData      = v.cd;
    link_if.outReady         = v.rdy;
  endtask

  task automatic checkState(input string tag, input logic cs, input logic [31:0] data,
                            input logic [1:0] grant, input logic [1:0] drop,
                            input logic lf, input logic rf, input logic cf);
    checkOutput({tag, " cs"},        32'(link_if.shiftOutCS), 32'(cs));
    checkOutput({tag, " data"},      link_if.shiftOutData,    data);
    checkOutput({tag, " grant"},     32'(link_if.grantId),    32'(grant));
    checkOutput({tag, " drop"},      32'(link_if.dropCount),  32'(drop));
    checkOutput({tag, " leftFull"},  32'(link_if.leftFull),   32'(lf));
    checkOutput({tag, " rightFull"}, 32'(link_if.rightFull),  32'(rf));
    checkOutput({tag, " localFull"}, 32'(link_if.localFull),  32'(cf));
  endtask

  // Row shorthand: pushes (cs,data) per source, ready, then expected outputs after the edge.
  function automatic vec_t mk(input logic lcs, input logic [31:0] ld, input logic rcs,
                              input logic [31:0] rd, input logic ccs, input logic [31:0] cd,
                              input logic rdy, input logic ecs, input logic [31:0] edata,
                              input logic [1:0] egrant, input logic [1:0] edrop,
                              input logic elf, input logic erf, input logic ecf);
    vec_t v;
    v.lcs = lcs; v.ld = ld; v.rcs = rcs; v.rd = rd; v.ccs = ccs; v.cd = cd; v.rdy = rdy;
    v.ecs = ecs; v.edata = edata; v.egrant = egrant; v.edrop = edrop;
    v.elf = elf; v.erf = erf; v.ecf = ecf;
    return v;
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // single local inject
    vecs.push_back(mk(0,0, 0,0, 1,32'h10924924, 1,  0,32'h0,        3,0, 0,0,0));
    vecs.push_back(mk(0,0, 0,0, 0,0,            1,  1,32'h10924924, 2,0, 0,0,0));
    vecs.push_back(mk(0,0, 0,0, 0,0,            1,  0,32'h10924924, 2,0, 0,0,0));
    vecs.push_back(mk(0,0, 0,0, 0,0,            1,  0,32'h10924924, 2,0, 0,0,0));
    // round robin, two simultaneous triples
    vecs.push_back(mk(1,32'hA, 1,32'hB, 1,32'hC, 1,  0,32'h10924924, 2,0, 0,0,0));
    vecs.push_back(mk(1,32'hA, 1,32'hB, 1,32'hC, 1,  1,32'hA, 0,0, 0,1,1));
    vecs.push_back(mk(0,0, 0,0, 0,0, 1,  0,32'hA, 0,0, 0,1,1));
    vecs.push_back(mk(0,0, 0,0, 0,0, 1,  0,32'hA, 0,0, 0,1,1));
    vecs.push_back(mk(0,0, 0,0, 0,0, 1,  1,32'hB, 1,0, 0,0,1));
    vecs.push_back(mk(0,0, 0,0, 0,0, 1,  0,32'hB, 1,0, 0,0,1));
    vecs.push_back(mk(0,0, 0,0, 0,0, 1,  0,32'hB, 1,0, 0,0,1));
    vecs.push_back(mk(0,0, 0,0, 0,0, 1,  1,32'hC, 2,0, 0,0,0));
    vecs.push_back(mk(0,0, 0,0, 0,0, 1,  0,32'hC, 2,0, 0,0,0));
    vecs.push_back(mk(0,0, 0,0, 0,0, 1,  0,32'hC, 2,0, 0,0,0));
    vecs.push_back(mk(0,0, 0,0, 0,0, 1,  1,32'hA, 0,0, 0,0,0));
    vecs.push_back(mk(0,0, 0,0, 0,0, 1,  0,32'hA, 0,0, 0,0,0));
    vecs.push_back(mk(0,0, 0,0, 0,0, 1,  0,32'hA, 0,0, 0,0,0));
    vecs.push_back(mk(0,0, 0,0, 0,0, 1,  1,32'hB, 1,0, 0,0,0));
    vecs.push_back(mk(0,0, 0,0, 0,0, 1,  0,32'hB, 1,0, 0,0,0));
    vecs.push_back(mk(0,0, 0,0, 0,0, 1,  0,32'hB, 1,0, 0,0,0));
    vecs.push_back(mk(0,0, 0,0, 0,0, 1,  1,32'hC, 2,0, 0,0,0));
    vecs.push_back(mk(0,0, 0,0, 0,0, 1,  0,32'hC, 2,0, 0,0,0));
    vecs.push_back(mk(0,0, 0,0, 0,0, 1,  0,32'hC, 2,0, 0,0,0));
    // backpressure, overflow drop, then drain
    vecs.push_back(mk(1,32'h1, 0,0, 0,0, 0,  0,32'hC, 2,0, 0,0,0));
    vecs.push_back(mk(1,32'h2, 0,0, 0,0, 0,  0,32'hC, 2,0, 1,0,0));
    vecs.push_back(mk(1,32'h3, 0,0, 0,0, 0,  0,32'hC, 2,1, 1,0,0));
    vecs.push_back(mk(0,0,     0,0, 0,0, 0,  0,32'hC, 2,1, 1,0,0));
    vecs.push_back(mk(0,0,     0,0, 0,0, 1,  1,32'h1, 0,1, 0,0,0));
    vecs.push_back(mk(0,0,     0,0, 0,0, 1,  0,32'h1, 0,1, 0,0,0));
    vecs.push_back(mk(0,0,     0,0, 0,0, 1,  0,32'h1, 0,1, 0,0,0));
    vecs.push_back(mk(0,0,     0,0, 0,0, 1,  1,32'h2, 0,1, 0,0,0));
    vecs.push_back(mk(0,0,     0,0, 0,0, 1,  0,32'h2, 0,1, 0,0,0));
    vecs.push_back(mk(0,0,     0,0, 0,0, 1,  0,32'h2, 0,1, 0,0,0));
    // full FIFO accepts a push on its pop edge
    vecs.push_back(mk(1,32'h1, 0,0, 0,0, 0,  0,32'h2, 0,1, 0,0,0));
    vecs.push_back(mk(1,32'h2, 0,0, 0,0, 0,  0,32'h2, 0,1, 1,0,0));
    vecs.push_back(mk(1,32'h4, 0,0, 0,0, 1,  1,32'h1, 0,1, 1,0,0));
    vecs.push_back(mk(0,0,     0,0, 0,0, 1,  0,32'h1, 0,1, 1,0,0));
    vecs.push_back(mk(0,0,     0,0, 0,0, 1,  0,32'h1, 0,1, 1,0,0));
    vecs.push_back(mk(0,0,     0,0, 0,0, 1,  1,32'h2, 0,1, 0,0,0));
    vecs.push_back(mk(0,0,     0,0, 0,0, 1,  0,32'h2, 0,1, 0,0,0));
    vecs.push_back(mk(0,0,     0,0, 0,0, 1,  0,32'h2, 0,1, 0,0,0));
    vecs.push_back(mk(0,0,     0,0, 0,0, 1,  1,32'h4, 0,1, 0,0,0));
    vecs.push_back(mk(0,0,     0,0, 0,0, 1,  0,32'h4, 0,1, 0,0,0));
    vecs.push_back(mk(0,0,     0,0, 0,0, 1,  0,32'h4, 0,1, 0,0,0));
    // double reject on one edge, then saturation of the 2-bit counter
    vecs.push_back(mk(1,32'h6,  0,0, 1,32'h5,  0,  0,32'h4, 0,1, 0,0,0));
    vecs.push_back(mk(1,32'h8,  0,0, 1,32'h7,  0,  0,32'h4, 0,1, 1,0,1));
    vecs.push_back(mk(1,32'hA0, 0,0, 1,32'h9,  0,  0,32'h4, 0,3, 1,0,1));
    vecs.push_back(mk(0,0,      0,0, 1,32'h11, 0,  0,32'h4, 0,3, 1,0,1));
    vecs.push_back(mk(0,0,      0,0, 1,32'h12, 0,  0,32'h4, 0,3, 1,0,1));
    vecs.push_back(mk(0,0,      0,0, 1,32'h13, 0,  0,32'h4, 0,3, 1,0,1));
    vecs.push_back(mk(0,0,      0,0, 1,32'h14, 0,  0,32'h4, 0,3, 1,0,1));
    vecs.push_back(mk(0,0,      0,0, 0,0,      1,  1,32'h5, 2,3, 1,0,0));

    reset = 1'b1;
    applyStimulus(mk(0,0, 0,0, 0,0, 0,  0,0, 0,0, 0,0,0));
    @(negedge clk);
    checkState("reset", 1'b0, 32'h0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkState($sformatf("row%0d", i), vecs[i].ecs, vecs[i].edata, vecs[i].egrant,
                 vecs[i].edrop, vecs[i].elf, vecs[i].erf, vecs[i].ecf);
    end

    // Mid-packet reset: the link is in SEND with packets still queued.
    applyStimulus(mk(0,0, 0,0, 0,0, 1,  0,0, 0,0, 0,0,0));
    reset = 1'b1;
    #1;
    checkState("async_reset", 1'b0, 32'h0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkState($sformatf("post_reset%0d", c), 1'b0, 32'h0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
